pipe_skid_reg: RTL and testbench

- Parametrised pipeline-stage register for the pipelined CPU; the successor to the fixed 32-bit enable register.
- Replaces the single enable with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Full throughput is sustained, and in_ready is derived only from registered state, with no combinational path from out_ready.
- Sits between pipeline stages, e.g. IF/ID and ID/EX, where downstream stalls and branch flushes must be absorbed.

---
 rtl/pipe_skid_reg.sv | 104 ++++++++++
 tb/tb_pipe_skid_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, a 2-entry skid buffer and synchronous flush.
// in_ready is a pure decode of the state register, so there is no combinational path from out_ready.
module pipe_skid_reg #(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding equals the entry count, so occupancy doubles as the FSM state view.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // Neither side may make valid depend on ready; in_ready never depends on out_ready.

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (accept && emit) begin
          main_d = in_data;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the only event is draining the main entry.
        if (emit) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush wins over every transition; an emit in this cycle is still delivered.
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed streaming, stall, flush and async-reset scenarios,
// plus a randomised handshake phase checked through an expected-data queue.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic       c_flush;
  logic       c_in_valid;
  logic       c_in_ready;
  logic [7:0] c_in_data;
  logic       c_out_valid;
  logic       c_out_ready;
  logic [7:0] c_out_data;
  logic [1:0] c_occupancy;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data  = '0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CLEAR_ON_FLUSH(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h5A), .CLEAR_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occupancy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Driver: one beat of stimulus; the expected queue mirrors what the stage should hold.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    if (v && in_ready && !fl) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  task automatic c_step(input logic v, input logic [7:0] d, input logic fl);
    c_in_valid = v;
    c_in_data  = d;
    c_flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares on every emit, and watches hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid && !prev_flush)
        check("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL emit_underflow: got data %0h, expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      check("occ_max", (occupancy <= 2'd2), 1'b1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flush = flush;
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_c_out_data", c_out_data, 8'h5A);
    rst = 1'b1;

    // Streaming: one beat per cycle, no bubbles
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i, 1'b1, 1'b0);
      check("stream_data", out_data, i);
      check("stream_occ", occupancy, 2'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_drain_occ", occupancy, 2'd0);

    // Stall and skid
    step(1'b1, 32'hA, 1'b0, 1'b0);
    check("skid_one_data", out_data, 32'hA);
    check("skid_one_ready", in_ready, 1'b1);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check("skid_full_occ", occupancy, 2'd2);
    check("skid_full_ready", in_ready, 1'b0);
    check("skid_full_data", out_data, 32'hA);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    check("skid_blocked_data", out_data, 32'hA);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("skid_first_emit_ready", in_ready, 1'b1);
    check("skid_second_data", out_data, 32'hB);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("skid_drained", out_valid, 1'b0);

    // Flush from FULL with a beat offered
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    check("flush_occ", occupancy, 2'd0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_hold_data", out_data, 32'hA);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_no_c", out_valid, 1'b0);

    // Flush coinciding with an emit
    step(1'b1, 32'hD, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("flush_emit_occ", occupancy, 2'd0);

    // Clearing variant
    c_step(1'b1, 8'h11, 1'b0);
    c_step(1'b1, 8'h22, 1'b0);
    check("c_full_occ", c_occupancy, 2'd2);
    check("c_full_data", c_out_data, 8'h11);
    c_step(1'b1, 8'h33, 1'b1);
    check("c_flush_occ", c_occupancy, 2'd0);
    check("c_flush_data", c_out_data, 8'h5A);
    c_step(1'b1, 8'h44, 1'b0);
    check("c_after_flush_data", c_out_data, 8'h44);
    c_step(1'b0, 8'h00, 1'b0);

    // Async reset in the middle of a cycle while FULL
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b1, 32'hF, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_occ", occupancy, 2'd0);
    check("async_out_data", out_data, 32'h0);
    check("async_in_ready", in_ready, 1'b1);
    check("async_c_out_data", c_out_data, 8'h5A);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomised handshake with occasional flush
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_occ", occupancy, 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
